// File: rtl/sudoku_pkg.sv
// ============================================================================
// sudoku_pkg : shared types and constants for the Sudoku loader
// Revision   : 1.0
// ============================================================================
`default_nettype none

package sudoku_pkg;

  localparam int N = 9;

  typedef logic [8:0] cand_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } loader_state_t;

  // Box number 0..8 from box-row / box-column counters.
  function automatic logic [3:0] box_idx(input logic [1:0] br, input logic [1:0] bc);
    return 4'(br) * 4'd3 + 4'(bc);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sudoku_loader_if.sv
// ============================================================================
// sudoku_loader_if : digit stream in, one-hot grid and status out
// Revision         : 1.0
// ============================================================================
`default_nettype none

interface sudoku_loader_if;
  import sudoku_pkg::*;

  logic             i_Valid;
  logic [3:0]       i_Digit;
  logic             o_Ready;
  cand_t [8:0][8:0] o_Grid;
  logic             o_Grid_Valid;
  logic             o_Load;
  logic             o_Conflict;
  logic             o_Err_Digit;
  logic             i_Ack;

  modport master (
    output i_Valid, i_Digit, i_Ack,
    input  o_Ready, o_Grid, o_Grid_Valid, o_Load, o_Conflict, o_Err_Digit
  );

  modport slave (
    input  i_Valid, i_Digit, i_Ack,
    output o_Ready, o_Grid, o_Grid_Valid, o_Load, o_Conflict, o_Err_Digit
  );

endinterface

`default_nettype wire

// File: rtl/sudoku_digit_decode.sv
// ============================================================================
// sudoku_digit_decode : decimal digit to one-hot candidate plus class flags
// Revision            : 1.0
// ============================================================================
`default_nettype none

module sudoku_digit_decode
  import sudoku_pkg::*;
(
  input  logic [3:0] i_Digit,
  output cand_t      o_Cand,
  output logic       o_Is_Clue,
  output logic       o_Is_Illegal
);

  always_comb begin
    o_Cand       = '0;
    o_Is_Clue    = 1'b0;
    o_Is_Illegal = 1'b0;
    if (i_Digit >= 4'd10) begin
      o_Is_Illegal = 1'b1;
    end else if (i_Digit != 4'd0) begin
      o_Is_Clue = 1'b1;
      o_Cand    = cand_t'(1) << (i_Digit - 4'd1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sudoku_loader.sv
// ============================================================================
// sudoku_loader : fills a 9x9 one-hot grid from a digit stream, checks clues
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sudoku_loader
  import sudoku_pkg::*;
(
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  sudoku_loader_if.slave  bus
);

  loader_state_t          state_q, state_d;
  logic [3:0]             row_q, row_d, col_q, col_d;
  logic [1:0]             br_q, br_d, bc_q, bc_d;
  cand_t [N-1:0]          row_mask_q, row_mask_d;
  cand_t [N-1:0]          col_mask_q, col_mask_d;
  cand_t [N-1:0]          box_mask_q, box_mask_d;
  cand_t [N-1:0][N-1:0]   grid_q, grid_d;
  logic                   conflict_q, conflict_d;
  logic                   err_q, err_d;

  cand_t                  dec_cand;
  logic                   dec_clue;
  logic                   dec_illegal;
  logic                   accept;
  logic [3:0]             box;

  sudoku_digit_decode u_decode (
    .i_Digit      (bus.i_Digit),
    .o_Cand       (dec_cand),
    .o_Is_Clue    (dec_clue),
    .o_Is_Illegal (dec_illegal)
  );

  assign accept = bus.i_Valid && (state_q == FILL);
  assign box    = box_idx(br_q, bc_q);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    br_d       = br_q;
    bc_d       = bc_q;
    row_mask_d = row_mask_q;
    col_mask_d = col_mask_q;
    box_mask_d = box_mask_q;
    grid_d     = grid_q;
    conflict_d = conflict_q;
    err_d      = err_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          grid_d[row_q][col_q] = dec_cand;
          if (dec_clue) begin
            if (|((row_mask_q[row_q] | col_mask_q[col_q] | box_mask_q[box]) & dec_cand))
              conflict_d = 1'b1;
            row_mask_d[row_q] = row_mask_q[row_q] | dec_cand;
            col_mask_d[col_q] = col_mask_q[col_q] | dec_cand;
            box_mask_d[box]   = box_mask_q[box] | dec_cand;
          end
          if (dec_illegal)
            err_d = 1'b1;

          // Box counters step at the 3/6 boundaries so no divide is needed.
          if (col_q == 4'd8) begin
            col_d = 4'd0;
            bc_d  = 2'd0;
            if (row_q == 4'd8) begin
              row_d   = 4'd0;
              br_d    = 2'd0;
              state_d = LOAD;
            end else begin
              row_d = row_q + 4'd1;
              if (row_q == 4'd2 || row_q == 4'd5)
                br_d = br_q + 2'd1;
            end
          end else begin
            col_d = col_q + 4'd1;
            if (col_q == 4'd2 || col_q == 4'd5)
              bc_d = bc_q + 2'd1;
          end
        end
      end

      LOAD: state_d = HOLD;

      HOLD: begin
        // Grid is left in place; the next puzzle overwrites every cell.
        if (bus.i_Ack) begin
          state_d    = FILL;
          row_d      = 4'd0;
          col_d      = 4'd0;
          br_d       = 2'd0;
          bc_d       = 2'd0;
          row_mask_d = '0;
          col_mask_d = '0;
          box_mask_d = '0;
          conflict_d = 1'b0;
          err_d      = 1'b0;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= FILL;
      row_q      <= 4'd0;
      col_q      <= 4'd0;
      br_q       <= 2'd0;
      bc_q       <= 2'd0;
      row_mask_q <= '0;
      col_mask_q <= '0;
      box_mask_q <= '0;
      grid_q     <= '0;
      conflict_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      br_q       <= br_d;
      bc_q       <= bc_d;
      row_mask_q <= row_mask_d;
      col_mask_q <= col_mask_d;
      box_mask_q <= box_mask_d;
      grid_q     <= grid_d;
      conflict_q <= conflict_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_Ready      = (state_q == FILL);
  assign bus.o_Load       = (state_q == LOAD);
  assign bus.o_Grid_Valid = (state_q != FILL);
  assign bus.o_Grid       = grid_q;
  assign bus.o_Conflict   = conflict_q;
  assign bus.o_Err_Digit  = err_q;

endmodule

`default_nettype wire
